// File: rtl/obi_sram_ctrl.sv
// OBI subordinate driving a single-port synchronous SRAM, with an optional
// grant wait-state generator and out-of-range access flagging.
module obi_sram_ctrl #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 39,
    parameter int BE_BITS    = DATA_W / 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int GNT_WAIT   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [BE_BITS-1:0]    be_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  err_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [BE_BITS-1:0]    sram_wmask_o,
    output logic [DEPTH_LOG2-1:0] sram_addr_o,
    output logic [DATA_W-1:0]     sram_wdata_o,
    input  logic [DATA_W-1:0]     sram_rdata_i
);

    localparam int OFF_W  = $clog2(BE_BITS);
    localparam int IDX_HI = DEPTH_LOG2 + OFF_W;
    localparam logic [3:0] WAIT_LOAD = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

    generate
        if (GNT_WAIT < 0 || GNT_WAIT > 15) begin : g_bad_gnt_wait
            $error("obi_sram_ctrl: GNT_WAIT must be in 0..15");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       rvalid_q;
    logic       rerr_q;
    logic       in_range;
    logic       gnt;
    logic       access;
    logic       unused_addr_lo;

    assign in_range       = ~|addr_i[ADDR_W-1:IDX_HI];
    assign unused_addr_lo = ^addr_i[OFF_W-1:0];

    // Grant is combinational so a zero-wait memory sustains one access per cycle.
    assign gnt = !rst_i && req_i &&
                 ((state_q == S_IDLE && GNT_WAIT == 0) ||
                  (state_q == S_WAIT && cnt_q == 4'd0));
    assign access = gnt && in_range;

    assign gnt_o        = gnt;
    assign sram_ce_o    = access;
    assign sram_we_o    = access && we_i;
    assign sram_addr_o  = addr_i[IDX_HI-1:OFF_W];
    assign sram_wdata_o = wdata_i;
    assign sram_wmask_o = be_i;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = (rvalid_q && !rerr_q) ? sram_rdata_i : '0;
    assign err_o    = (gnt && we_i && !in_range) || (rvalid_q && rerr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= gnt && !we_i;
            rerr_q   <= !in_range;
            case (state_q)
                S_IDLE: begin
                    if (req_i && GNT_WAIT != 0) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    // A dropped request abandons the pending grant entirely.
                    if (!req_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi_sram_ctrl.sv
// Directed bench for obi_sram_ctrl: a zero-wait instance driven from a vector
// table, and a three-wait instance for the wait-state sequences.
module tb_obi_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // zero-wait instance
    logic        req0, we0;
    logic [7:0]  be0;
    logic [38:0] addr0;
    logic [63:0] wdata0;
    logic        gnt0, rvalid0, err0, ce0, swe0;
    logic [63:0] rdata0, swdata0, srd0;
    logic [7:0]  wmask0;
    logic [9:0]  saddr0;

    // three-wait instance
    logic        req1, we1;
    logic [7:0]  be1;
    logic [38:0] addr1;
    logic [63:0] wdata1;
    logic        gnt1, rvalid1, err1, ce1, swe1;
    logic [63:0] rdata1, swdata1, srd1;
    logic [7:0]  wmask1;
    logic [9:0]  saddr1;

    obi_sram_ctrl #(.GNT_WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .be_i(be0),
        .addr_i(addr0), .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0), .sram_ce_o(ce0), .sram_we_o(swe0),
        .sram_wmask_o(wmask0), .sram_addr_o(saddr0), .sram_wdata_o(swdata0),
        .sram_rdata_i(srd0));

    obi_sram_ctrl #(.GNT_WAIT(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .be_i(be1),
        .addr_i(addr1), .wdata_i(wdata1), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .sram_ce_o(ce1), .sram_we_o(swe1),
        .sram_wmask_o(wmask1), .sram_addr_o(saddr1), .sram_wdata_o(swdata1),
        .sram_rdata_i(srd1));

    // behavioural SRAM macros
    logic [63:0] mem0 [1024];
    logic [63:0] mem1 [1024];
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 64'h0;
            mem1[i] = 64'h0;
        end
        mem1[8] = 64'h0123456789ABCDEF;
    end
    always @(posedge clk) begin
        if (ce0) begin
            if (swe0) begin
                for (int b = 0; b < 8; b++)
                    if (wmask0[b]) mem0[saddr0][b*8 +: 8] <= swdata0[b*8 +: 8];
            end else srd0 <= mem0[saddr0];
        end
        if (ce1) begin
            if (swe1) begin
                for (int b = 0; b < 8; b++)
                    if (wmask1[b]) mem1[saddr1][b*8 +: 8] <= swdata1[b*8 +: 8];
            end else srd1 <= mem1[saddr1];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  be;
        logic [38:0] addr;
        logic [63:0] wdata;
        logic        exp_ce;
        logic [9:0]  exp_saddr;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [14];

    initial begin
        vt[0]  = '{1'b1, 8'hFF, 39'h40,    64'hDEADBEEFCAFEF00D, 1'b1, 10'd8,    64'h0, 1'b0};
        vt[1]  = '{1'b0, 8'hFF, 39'h40,    64'h0,                1'b1, 10'd8,    64'hDEADBEEFCAFEF00D, 1'b0};
        vt[2]  = '{1'b1, 8'hFF, 39'h40,    64'hFFFFFFFFFFFFFFFF, 1'b1, 10'd8,    64'h0, 1'b0};
        vt[3]  = '{1'b1, 8'h0F, 39'h40,    64'h1111111122222222, 1'b1, 10'd8,    64'h0, 1'b0};
        vt[4]  = '{1'b0, 8'hFF, 39'h40,    64'h0,                1'b1, 10'd8,    64'hFFFFFFFF22222222, 1'b0};
        vt[5]  = '{1'b0, 8'hFF, 39'h2000,  64'h0,                1'b0, 10'd0,    64'h0, 1'b1};
        vt[6]  = '{1'b1, 8'hFF, 39'h2000,  64'h5555555555555555, 1'b0, 10'd0,    64'h0, 1'b1};
        vt[7]  = '{1'b0, 8'hFF, 39'h47,    64'h0,                1'b1, 10'd8,    64'hFFFFFFFF22222222, 1'b0};
        vt[8]  = '{1'b1, 8'hF0, 39'h1FF8,  64'hA5A5A5A5FFFFFFFF, 1'b1, 10'd1023, 64'h0, 1'b0};
        vt[9]  = '{1'b0, 8'hFF, 39'h1FF8,  64'h0,                1'b1, 10'd1023, 64'hA5A5A5A500000000, 1'b0};
        vt[10] = '{1'b0, 8'hFF, 39'h4000000000, 64'h0,           1'b0, 10'd0,    64'h0, 1'b1};
        vt[11] = '{1'b1, 8'hFF, 39'h0,     64'h1000000000000001, 1'b1, 10'd0,    64'h0, 1'b0};
        vt[12] = '{1'b1, 8'hFF, 39'h8,     64'h2000000000000002, 1'b1, 10'd1,    64'h0, 1'b0};
        vt[13] = '{1'b1, 8'hFF, 39'h10,    64'h3000000000000003, 1'b1, 10'd2,    64'h0, 1'b0};
    end

    logic [63:0] b2b_exp [3];

    initial begin
        b2b_exp[0] = 64'h1000000000000001;
        b2b_exp[1] = 64'h2000000000000002;
        b2b_exp[2] = 64'h3000000000000003;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; be0 = 8'hFF; addr0 = 39'h40; wdata0 = 64'h0;
        req1 = 1'b0; we1 = 1'b0; be1 = 8'hFF; addr1 = 39'h0;  wdata1 = 64'h0;

        // reset state, with a request pending on the zero-wait port
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt0, 0);
        chk("rst_rvalid", rvalid0, 0);
        chk("rst_rdata", rdata0, 0);
        chk("rst_err", err0, 0);
        chk("rst_ce", ce0, 0);
        chk("rst_we", swe0, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // single transactions from the table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req0 = 1'b1; we0 = vt[i].we; be0 = vt[i].be;
            addr0 = vt[i].addr; wdata0 = vt[i].wdata;
            #1;
            chk($sformatf("v%0d_gnt", i), gnt0, 1);
            chk($sformatf("v%0d_ce", i), ce0, vt[i].exp_ce);
            chk($sformatf("v%0d_swe", i), swe0, vt[i].exp_ce & vt[i].we);
            chk($sformatf("v%0d_err_gnt", i), err0, vt[i].we & vt[i].exp_err);
            if (vt[i].exp_ce) chk($sformatf("v%0d_saddr", i), saddr0, vt[i].exp_saddr);
            if (vt[i].exp_ce && vt[i].we) chk($sformatf("v%0d_wmask", i), wmask0, vt[i].be);
            @(negedge clk);
            req0 = 1'b0;
            #1;
            chk($sformatf("v%0d_rvalid", i), rvalid0, !vt[i].we);
            chk($sformatf("v%0d_err_rsp", i), err0, !vt[i].we & vt[i].exp_err);
            if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rdata0, vt[i].exp_rdata);
        end

        // back-to-back reads with req held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0 = 1'b1; we0 = 1'b0; addr0 = 39'(i * 8);
            #1;
            chk($sformatf("b2b%0d_gnt", i), gnt0, 1);
            chk($sformatf("b2b%0d_saddr", i), saddr0, 64'(i));
            if (i > 0) begin
                chk($sformatf("b2b%0d_rvalid", i - 1), rvalid0, 1);
                chk($sformatf("b2b%0d_rdata", i - 1), rdata0, b2b_exp[i - 1]);
            end
        end
        @(negedge clk);
        req0 = 1'b0;
        #1;
        chk("b2b2_rvalid", rvalid0, 1);
        chk("b2b2_rdata", rdata0, b2b_exp[2]);
        @(negedge clk);
        chk("b2b_idle_rvalid", rvalid0, 0);

        // wait-state read: grant exactly 3 cycles after req rises
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 39'h40;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("ws_gnt_k%0d", k), gnt1, k == 3);
        end
        chk("ws_saddr", saddr1, 8);
        chk("ws_ce", ce1, 1);
        @(negedge clk);
        req1 = 1'b0;
        #1;
        chk("ws_rvalid", rvalid1, 1);
        chk("ws_rdata", rdata1, 64'h0123456789ABCDEF);
        @(negedge clk);
        chk("ws_rvalid_off", rvalid1, 0);

        // request dropped during wait, then a fresh write waits the full count
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 39'h48; wdata1 = 64'hFEEDFACE00C0FFEE;
        @(negedge clk);
        req1 = 1'b0;
        #1;
        chk("drop_gnt", gnt1, 0);
        @(negedge clk);
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("ws_wr_gnt_k%0d", k), gnt1, k == 3);
        end
        chk("ws_wr_swe", swe1, 1);
        chk("ws_wr_saddr", saddr1, 9);
        @(negedge clk);
        req1 = 1'b0;
        #1;
        chk("ws_wr_no_rvalid", rvalid1, 0);
        chk("ws_wr_mem", mem1[9], 64'hFEEDFACE00C0FFEE);

        // reset during the response cycle of a read drops the response
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 39'h40;
        #1;
        chk("mid_gnt", gnt0, 1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        chk("mid_rvalid_pre", rvalid0, 1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid", rvalid0, 0);
        chk("mid_rdata", rdata0, 0);
        chk("mid_err", err0, 0);
        chk("mid_ce", ce0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_after", rvalid0, 0);
        @(negedge clk);
        chk("mid_rvalid_after2", rvalid0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
